syndrome_sequencer: RTL and testbench

// Computes the 2t syndromes S_j = r(alpha^j), j=1..NSYN, of one received RS codeword over GF(2^5).

---
 rtl/syndrome_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_syndrome_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_sequencer.sv
// ---------------------------------------------------------------------------
// syndrome_sequencer
// Computes the syndromes S_j = r(alpha^j), j = 1..NSYN, of one received
// Reed-Solomon codeword over GF(2^5) (primitive polynomial x^5 + x^2 + 1).
// Horner's rule is evaluated on one shared GF multiplier and one GF adder.
// The multiplier is time-multiplexed across the syndromes, so one S_j is
// updated per cycle and one symbol is taken every NSYN+1 cycles.
//
// Ports
//   clock      in   1        rising-edge clock
//   reset_n    in   1        synchronous reset, active low
//   sym_in     in   5        received symbol, r_{N-1} first
//   sym_valid  in   1        sym_in is valid
//   sym_ready  out  1        a symbol can be accepted this cycle
//   syn_out    out  5*NSYN   syndromes, S_1 at [4:0], S_j at [5j-1:5j-5]
//   syn_valid  out  1        syn_out holds a complete, stable result
//   syn_ready  in   1        downstream consumes the result
//   syn_zero   out  1        all syndromes are zero (valid with syn_valid)
//   busy       out  1        a codeword is in progress
// ---------------------------------------------------------------------------

// GF(2^5) multiplier, shift-and-add with modular reduction on every shift.
module lcpmult (
   input  logic [4:0] a,
   input  logic [4:0] b,
   output logic [4:0] p
);
   function automatic logic [4:0] xtime(input logic [4:0] v);
      // x^5 folds back to x^2 + 1
      return {v[3:0], 1'b0} ^ (v[4] ? 5'h05 : 5'h00);
   endfunction

   function automatic logic [4:0] gf_mul(input logic [4:0] x, input logic [4:0] y);
      logic [4:0] acc;
      logic [4:0] sh;
      acc = 5'h00;
      sh  = x;
      for (int i = 0; i < 5; i++) begin
         if (y[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   always_comb p = gf_mul(a, b);
endmodule

// GF(2^5) adder: carry-less addition.
module gfadder (
   input  logic [4:0] a,
   input  logic [4:0] b,
   output logic [4:0] s
);
   assign s = a ^ b;
endmodule

module syndrome_sequencer #(
   parameter int N    = 31,
   parameter int NSYN = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [4:0]        sym_in,
   input  logic              sym_valid,
   output logic              sym_ready,
   output logic [5*NSYN-1:0] syn_out,
   output logic              syn_valid,
   input  logic              syn_ready,
   output logic              syn_zero,
   output logic              busy
);
   localparam int JW = (NSYN > 1) ? $clog2(NSYN) : 1;

   function automatic logic [4:0] xtime(input logic [4:0] v);
      return {v[3:0], 1'b0} ^ (v[4] ? 5'h05 : 5'h00);
   endfunction

   // alpha^1 .. alpha^NSYN, entry k holds alpha^(k+1)
   function automatic logic [5*NSYN-1:0] build_alpha_rom();
      logic [5*NSYN-1:0] rom;
      logic [4:0]        a;
      rom = '0;
      a   = 5'h01;
      for (int k = 0; k < NSYN; k++) begin
         a = xtime(a);
         rom[5*k +: 5] = a;
      end
      return rom;
   endfunction

   localparam logic [5*NSYN-1:0] ALPHA_ROM = build_alpha_rom();

   typedef enum logic [1:0] {WAIT, ITER, DONE} state_t;

   state_t            state, state_nx;
   logic [4:0]        sym_cnt;
   logic [JW-1:0]     j;
   logic              first;
   logic [4:0]        sym_reg;
   logic [5*NSYN-1:0] syn_reg;

   logic              last_j;
   logic [4:0]        old_s;
   logic [4:0]        alpha_sel;
   logic [4:0]        prod;
   logic [4:0]        upd;

   assign last_j    = (j == JW'(NSYN - 1));
   // On the first symbol of a codeword the stale syndrome is replaced by 0,
   // which makes the Horner update collapse to S = r_{N-1}.
   assign old_s     = first ? 5'h00 : syn_reg[5*j +: 5];
   assign alpha_sel = ALPHA_ROM[5*j +: 5];

   lcpmult u_mult (
      .a (old_s),
      .b (alpha_sel),
      .p (prod)
   );

   gfadder u_add (
      .a (prod),
      .b (sym_reg),
      .s (upd)
   );

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) state <= WAIT;
      else          state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         WAIT: if (sym_valid) state_nx = ITER;
         ITER: if (last_j) state_nx = (sym_cnt == 5'(N - 1)) ? DONE : WAIT;
         DONE: if (syn_ready) state_nx = WAIT;
         default: state_nx = WAIT;
      endcase
   end

   // Outputs decoded from registered state
   always_comb begin
      sym_ready = (state == WAIT);
      syn_valid = (state == DONE);
      busy      = (state != WAIT) || (sym_cnt != 5'd0);
      syn_zero  = (syn_reg == '0);
      syn_out   = syn_reg;
   end

   // Counters and syndrome accumulators
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sym_cnt <= 5'd0;
         j       <= '0;
         first   <= 1'b1;
         syn_reg <= '0;
      end else begin
         unique case (state)
            WAIT: begin
               if (sym_valid) j <= '0;
            end
            ITER: begin
               syn_reg[5*j +: 5] <= upd;
               j <= j + 1'b1;
               if (last_j) begin
                  first   <= 1'b0;
                  sym_cnt <= sym_cnt + 5'd1;
               end
            end
            DONE: begin
               if (syn_ready) begin
                  sym_cnt <= 5'd0;
                  first   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Symbol holding register carries data only, so it is left out of reset.
   always_ff @(posedge clock) begin
      if (state == WAIT && sym_valid) sym_reg <= sym_in;
   end
endmodule

// File: tb/tb_syndrome_sequencer.sv
module tb_syndrome_sequencer;
   localparam int N    = 31;
   localparam int NSYN = 4;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [4:0]        sym_in;
   logic              sym_valid;
   logic              sym_ready;
   logic [5*NSYN-1:0] syn_out;
   logic              syn_valid;
   logic              syn_ready;
   logic              syn_zero;
   logic              busy;

   always #5 clock = ~clock;

   syndrome_sequencer #(.N(N), .NSYN(NSYN)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .sym_in    (sym_in),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .syn_out   (syn_out),
      .syn_valid (syn_valid),
      .syn_ready (syn_ready),
      .syn_zero  (syn_zero),
      .busy      (busy)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clock) cyc = cyc + 1;

   logic [4:0]        r [0:N-1];      // r[i] = coefficient of x^i
   logic [5*NSYN-1:0] exp_syn = '0;
   int                acc_t [0:N-1];

   // ---------------- reference model: direct polynomial evaluation --------
   function automatic logic [4:0] gf_mul_ref(input logic [4:0] a, input logic [4:0] b);
      logic [8:0] p;
      p = 9'h000;
      for (int i = 0; i < 5; i++)
         if (b[i]) p = p ^ (9'(a) << i);
      for (int k = 8; k >= 5; k--)
         if (p[k]) p = p ^ (9'h025 << (k - 5));
      return p[4:0];
   endfunction

   function automatic logic [4:0] alpha_pow(input int e);
      logic [4:0] v;
      v = 5'h01;
      for (int i = 0; i < e; i++) v = gf_mul_ref(v, 5'h02);
      return v;
   endfunction

   function automatic logic [5*NSYN-1:0] model_syn();
      logic [5*NSYN-1:0] res;
      logic [4:0]        s;
      res = '0;
      for (int jj = 1; jj <= NSYN; jj++) begin
         s = 5'h00;
         for (int i = 0; i < N; i++)
            s = s ^ gf_mul_ref(r[i], alpha_pow((i * jj) % 31));
         res[5*(jj-1) +: 5] = s;
      end
      return res;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- per-cycle compare against the model ------------------
   always @(negedge clock) begin
      if (reset_n === 1'b1 && syn_valid === 1'b1) begin
         check("syn_out", 32'(syn_out), 32'(exp_syn));
         check("syn_zero", 32'(syn_zero), 32'(exp_syn == '0));
         check("sym_ready_in_done", 32'(sym_ready), 32'd0);
         check("busy_in_done", 32'(busy), 32'd1);
      end
   end

   // ---------------- stimulus helpers -------------------------------------
   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic feed(input logic [4:0] s, input bit hold, output int t_acc);
      int k;
      k = 0;
      sym_valid = 1'b1;
      while (sym_ready !== 1'b1 && k < 50) begin
         @(negedge clock);
         k++;
      end
      if (sym_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL feed_timeout: sym_ready stayed %b, expected 1", sym_ready);
         t_acc = -1;
      end else begin
         sym_in = s;
         @(posedge clock);
         #1 t_acc = cyc;
         @(negedge clock);
      end
      if (!hold) sym_valid = 1'b0;
   endtask

   task automatic send_cw(input bit hold);
      int t;
      exp_syn = model_syn();
      for (int i = N - 1; i >= 0; i--) begin
         feed(r[i], hold, t);
         acc_t[i] = t;
      end
      sym_valid = 1'b0;
   endtask

   // syn_valid must be low NSYN-1 edges after the last accept and high at NSYN.
   task automatic expect_done();
      repeat (NSYN - 1) @(negedge clock);
      check("syn_valid_early", 32'(syn_valid), 32'd0);
      @(negedge clock);
      check("syn_valid_latency", 32'(syn_valid), 32'd1);
   endtask

   task automatic release_result();
      syn_ready = 1'b1;
      @(negedge clock);
      syn_ready = 1'b0;
      check("sym_ready_after_consume", 32'(sym_ready), 32'd1);
      check("syn_valid_after_consume", 32'(syn_valid), 32'd0);
      check("busy_after_consume", 32'(busy), 32'd0);
   endtask

   task automatic clear_r();
      for (int i = 0; i < N; i++) r[i] = 5'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      sym_valid = 1'b0;
      syn_ready = 1'b0;
      sym_in    = 5'h00;
      clear_r();
      repeat (3) @(negedge clock);
      reset_n = 1'b1;

      // reset state
      check("rst_sym_ready", 32'(sym_ready), 32'd1);
      check("rst_syn_valid", 32'(syn_valid), 32'd0);
      check("rst_syn_zero", 32'(syn_zero), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_syn_out", 32'(syn_out), 32'd0);

      // T1: all-zero codeword
      clear_r();
      send_cw(1'b0);
      expect_done();
      release_result();

      // T2: r_0 = 7, syn_ready high throughout (ignored until DONE)
      clear_r();
      r[0] = 5'h07;
      check("model_t2", 32'(model_syn()), 32'({5'h07, 5'h07, 5'h07, 5'h07}));
      syn_ready = 1'b1;
      send_cw(1'b0);
      expect_done();
      release_result();

      // T3: r_1 = 1
      clear_r();
      r[1] = 5'h01;
      check("model_t3", 32'(model_syn()), 32'({5'h10, 5'h08, 5'h04, 5'h02}));
      send_cw(1'b0);
      expect_done();
      release_result();

      // T4: r_30 = 1
      clear_r();
      r[30] = 5'h01;
      check("model_t4", 32'(model_syn()), 32'({5'h0B, 5'h16, 5'h09, 5'h12}));
      send_cw(1'b0);
      expect_done();
      release_result();

      // T5: sym_valid held high, then result held off for 10 cycles
      for (int i = 0; i < N; i++) r[i] = 5'((i * 7 + 3) % 32);
      send_cw(1'b1);
      for (int i = N - 1; i >= N - 5; i--)
         check("accept_interval", 32'(acc_t[i - 1] - acc_t[i]), 32'(NSYN + 1));
      expect_done();
      repeat (10) begin
         @(negedge clock);
         check("hold_syn_valid", 32'(syn_valid), 32'd1);
         check("hold_sym_ready", 32'(sym_ready), 32'd0);
      end
      release_result();

      // T6: reset after 10 symbols, then a full T3 codeword
      clear_r();
      r[30] = 5'h01;
      r[25] = 5'h1F;
      for (int i = N - 1; i >= N - 10; i--) begin
         int t;
         feed(r[i], 1'b0, t);
      end
      check("busy_mid_codeword", 32'(busy), 32'd1);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      check("mid_rst_sym_ready", 32'(sym_ready), 32'd1);
      check("mid_rst_syn_valid", 32'(syn_valid), 32'd0);
      check("mid_rst_syn_zero", 32'(syn_zero), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_syn_out", 32'(syn_out), 32'd0);
      clear_r();
      r[1] = 5'h01;
      send_cw(1'b0);
      expect_done();
      check("t6_literal", 32'(syn_out), 32'({5'h10, 5'h08, 5'h04, 5'h02}));
      release_result();

      repeat (2) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
